// File: rtl/rv_decode_pkg.sv
// Shared decode constants and types: RV32I/RV64I opcodes, funct fields,
// the instruction format code and the per-entry control bundle.
package rv_decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [2:0] F3_BR_RSV0 = 3'b010;
  localparam logic [2:0] F3_BR_RSV1 = 3'b011;
  localparam logic [2:0] F3_LB      = 3'b000;
  localparam logic [2:0] F3_LH      = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_LD      = 3'b011;
  localparam logic [2:0] F3_LBU     = 3'b100;
  localparam logic [2:0] F3_LHU     = 3'b101;
  localparam logic [2:0] F3_LWU     = 3'b110;
  localparam logic [2:0] F3_SB      = 3'b000;
  localparam logic [2:0] F3_SH      = 3'b001;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_SD      = 3'b011;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_ALT  = 6'b010000;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef struct packed {
    fmt_e fmt;
    logic rd_we;
    logic rs1_en;
    logic rs2_en;
    logic illegal;
  } ctl_t;

endpackage

// File: rtl/rv_decode_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle; master is the
// surrounding pipeline (offers instructions, consumes entries), slave is the decoder.
interface rv_decode_if
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  fmt_e            out_fmt;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_f3;
  logic [6:0]      out_f7;
  logic [XLEN-1:0] out_imm;
  logic            out_rd_we;
  logic            out_rs1_en;
  logic            out_rs2_en;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_fmt, out_rd, out_rs1,
           out_rs2, out_f3, out_f7, out_imm, out_rd_we, out_rs1_en, out_rs2_en,
           out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_fmt, out_rd, out_rs1,
           out_rs2, out_f3, out_f7, out_imm, out_rd_we, out_rs1_en, out_rs2_en,
           out_illegal
  );
endinterface

// File: rtl/rv_imm_gen.sv
// Immediate generator: combinational, zero latency, no flow control.
// Formats without an immediate (R, NONE) yield zero.
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     i_instr,
  input  fmt_e            i_fmt,
  output logic [XLEN-1:0] o_imm
);

  logic [11:0] w_imm_i;
  logic [11:0] w_imm_s;
  logic [12:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [20:0] w_imm_j;

  assign w_imm_i = i_instr[31:20];
  assign w_imm_s = {i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  // Signed size casts replicate instr[31] up to XLEN.
  always_comb begin
    o_imm = '0;
    case (i_fmt)
      FMT_I:   o_imm = XLEN'($signed(w_imm_i));
      FMT_S:   o_imm = XLEN'($signed(w_imm_s));
      FMT_B:   o_imm = XLEN'($signed(w_imm_b));
      FMT_U:   o_imm = XLEN'($signed(w_imm_u));
      FMT_J:   o_imm = XLEN'($signed(w_imm_j));
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I/RV64I decode stage: 1-cycle registered output, 1 instr/cycle throughput.
// Output entry holds while out_ready=0; in_ready = !out_valid | out_ready, gated by flush.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  rv_decode_if.slave       dec,
  output logic [CNT_W-1:0] illegal_cnt
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("rv_decode_stage: XLEN must be 32 or 64");
    end
  endgenerate

  localparam bit IS_RV64 = (XLEN == 64);

  logic [31:0]     w_instr;
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [5:0]      w_f6;
  logic            w_legal;
  fmt_e            w_fmt;
  logic            w_rd_we;
  logic            w_rs1_en;
  logic            w_rs2_en;
  ctl_t            w_ctl;
  logic [XLEN-1:0] w_imm;
  logic            w_in_rdy;
  logic            w_acc;

  logic             r_vld;
  logic [31:0]      r_instr;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_imm;
  ctl_t             r_ctl;
  logic [CNT_W-1:0] r_cnt;

  assign w_instr = dec.in_instr;
  assign w_opc   = w_instr[6:0];
  assign w_f3    = w_instr[14:12];
  assign w_f7    = w_instr[31:25];
  assign w_f6    = w_instr[31:26];

  // Format, register usage and legality before the illegal override.
  always_comb begin
    w_legal  = 1'b0;
    w_fmt    = FMT_NONE;
    w_rd_we  = 1'b0;
    w_rs1_en = 1'b0;
    w_rs2_en = 1'b0;
    if (w_instr[1:0] == 2'b11) begin
      case (w_opc)
        OPC_LUI, OPC_AUIPC: begin
          w_fmt   = FMT_U;
          w_rd_we = 1'b1;
          w_legal = 1'b1;
        end
        OPC_JAL: begin
          w_fmt   = FMT_J;
          w_rd_we = 1'b1;
          w_legal = 1'b1;
        end
        OPC_JALR: begin
          w_fmt    = FMT_I;
          w_rs1_en = 1'b1;
          w_rd_we  = 1'b1;
          w_legal  = (w_f3 == F3_JALR);
        end
        OPC_BRANCH: begin
          w_fmt    = FMT_B;
          w_rs1_en = 1'b1;
          w_rs2_en = 1'b1;
          w_legal  = (w_f3 != F3_BR_RSV0) && (w_f3 != F3_BR_RSV1);
        end
        OPC_LOAD: begin
          w_fmt    = FMT_I;
          w_rs1_en = 1'b1;
          w_rd_we  = 1'b1;
          case (w_f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: w_legal = 1'b1;
            F3_LD, F3_LWU:                       w_legal = IS_RV64;
            default:                             w_legal = 1'b0;
          endcase
        end
        OPC_STORE: begin
          w_fmt    = FMT_S;
          w_rs1_en = 1'b1;
          w_rs2_en = 1'b1;
          case (w_f3)
            F3_SB, F3_SH, F3_SW: w_legal = 1'b1;
            F3_SD:               w_legal = IS_RV64;
            default:             w_legal = 1'b0;
          endcase
        end
        OPC_OPIMM: begin
          w_fmt    = FMT_I;
          w_rs1_en = 1'b1;
          w_rd_we  = 1'b1;
          // RV64 shamt is 6 bits wide, so instr[25] belongs to the shift amount.
          case (w_f3)
            F3_SLL:     w_legal = IS_RV64 ? (w_f6 == F6_BASE) : (w_f7 == F7_BASE);
            F3_SRL_SRA: w_legal = IS_RV64 ? ((w_f6 == F6_BASE) || (w_f6 == F6_ALT))
                                          : ((w_f7 == F7_BASE) || (w_f7 == F7_ALT));
            default:    w_legal = 1'b1;
          endcase
        end
        OPC_OP: begin
          w_fmt    = FMT_R;
          w_rs1_en = 1'b1;
          w_rs2_en = 1'b1;
          w_rd_we  = 1'b1;
          w_legal  = (w_f7 == F7_BASE) ||
                     ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SRL_SRA)));
        end
        OPC_FENCE: begin
          w_fmt   = FMT_I;
          w_legal = 1'b1;
        end
        OPC_SYSTEM: begin
          w_fmt   = FMT_I;
          w_legal = (w_instr == INSTR_ECALL) || (w_instr == INSTR_EBREAK);
        end
        default: w_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_ctl         = '0;
    w_ctl.fmt     = w_legal ? w_fmt : FMT_NONE;
    w_ctl.rd_we   = w_legal & w_rd_we & (w_instr[11:7] != 5'd0);
    w_ctl.rs1_en  = w_legal & w_rs1_en;
    w_ctl.rs2_en  = w_legal & w_rs2_en;
    w_ctl.illegal = ~w_legal;
  end

  rv_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .i_instr (w_instr[31:7]),
    .i_fmt   (w_ctl.fmt),
    .o_imm   (w_imm)
  );

  assign w_in_rdy = (~r_vld | dec.out_ready) & ~flush;
  assign w_acc    = dec.in_valid & w_in_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_imm   <= '0;
      r_ctl   <= '0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_vld <= 1'b0;
    end else if (w_acc) begin
      r_vld   <= 1'b1;
      r_instr <= w_instr;
      r_pc    <= dec.in_pc;
      r_imm   <= w_imm;
      r_ctl   <= w_ctl;
      if (w_ctl.illegal && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (dec.out_ready) begin
      r_vld <= 1'b0;
    end
  end

  assign dec.in_ready    = w_in_rdy;
  assign dec.out_valid   = r_vld;
  assign dec.out_pc      = r_pc;
  assign dec.out_opcode  = r_instr[6:0];
  assign dec.out_fmt     = r_ctl.fmt;
  assign dec.out_rd      = r_instr[11:7];
  assign dec.out_rs1     = r_instr[19:15];
  assign dec.out_rs2     = r_instr[24:20];
  assign dec.out_f3      = r_instr[14:12];
  assign dec.out_f7      = r_instr[31:25];
  assign dec.out_imm     = r_imm;
  assign dec.out_rd_we   = r_ctl.rd_we;
  assign dec.out_rs1_en  = r_ctl.rs1_en;
  assign dec.out_rs2_en  = r_ctl.rs2_en;
  assign dec.out_illegal = r_ctl.illegal;
  assign illegal_cnt     = r_cnt;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: one stimulus stream drives RV32, RV64 and a
// 2-bit-counter RV32 instance in lockstep; a scoreboard checks every entry.
module tb_rv_decode_stage;
  import rv_decode_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        we;
    logic        r1;
    logic        r2;
    logic        ill32;
    logic        ill64;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic [15:0] cnt32;
  logic [15:0] cnt64;
  logic [1:0]  cnts;

  rv_decode_if #(.XLEN(32)) if32 ();
  rv_decode_if #(.XLEN(64)) if64 ();
  rv_decode_if #(.XLEN(32)) ifs ();

  assign if32.in_valid  = in_valid;
  assign if32.in_instr  = in_instr;
  assign if32.in_pc     = in_pc[31:0];
  assign if32.out_ready = out_ready;
  assign if64.in_valid  = in_valid;
  assign if64.in_instr  = in_instr;
  assign if64.in_pc     = in_pc;
  assign if64.out_ready = out_ready;
  assign ifs.in_valid   = in_valid;
  assign ifs.in_instr   = in_instr;
  assign ifs.in_pc      = in_pc[31:0];
  assign ifs.out_ready  = out_ready;

  rv_decode_stage #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .dec(if32.slave), .illegal_cnt(cnt32));
  rv_decode_stage #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .dec(if64.slave), .illegal_cnt(cnt64));
  rv_decode_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .dec(ifs.slave), .illegal_cnt(cnts));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_run;
  int          n_fail;
  exp_t        sb[$];
  exp_t        cur;
  logic        mvld;
  int          cnt32_m;
  int          cnt64_m;
  int          cnts_m;
  logic [63:0] pc_ctr;

  function automatic exp_t mk(logic [31:0] instr, logic [2:0] fmt, logic [63:0] imm,
                              logic we, logic r1, logic r2, logic ill32, logic ill64);
    exp_t e;
    e.instr = instr; e.pc = '0; e.fmt = fmt; e.imm = imm;
    e.we = we; e.r1 = r1; e.r2 = r2; e.ill32 = ill32; e.ill64 = ill64;
    return e;
  endfunction

  function automatic logic [102:0] pack32(exp_t e);
    logic [2:0]  f;
    logic [31:0] im;
    logic [3:0]  c;
    if (e.ill32) begin f = 3'd7; im = '0; c = 4'b0001; end
    else begin f = e.fmt; im = e.imm[31:0]; c = {e.we, e.r1, e.r2, 1'b0}; end
    return {e.pc[31:0], e.instr[6:0], f, e.instr[11:7], e.instr[19:15], e.instr[24:20],
            e.instr[14:12], e.instr[31:25], im, c};
  endfunction

  function automatic logic [166:0] pack64(exp_t e);
    logic [2:0]  f;
    logic [63:0] im;
    logic [3:0]  c;
    if (e.ill64) begin f = 3'd7; im = '0; c = 4'b0001; end
    else begin f = e.fmt; im = e.imm; c = {e.we, e.r1, e.r2, 1'b0}; end
    return {e.pc, e.instr[6:0], f, e.instr[11:7], e.instr[19:15], e.instr[24:20],
            e.instr[14:12], e.instr[31:25], im, c};
  endfunction

  function automatic logic [102:0] dut32_pack();
    return {if32.out_pc, if32.out_opcode, if32.out_fmt, if32.out_rd, if32.out_rs1,
            if32.out_rs2, if32.out_f3, if32.out_f7, if32.out_imm, if32.out_rd_we,
            if32.out_rs1_en, if32.out_rs2_en, if32.out_illegal};
  endfunction

  function automatic logic [102:0] dutsat_pack();
    return {ifs.out_pc, ifs.out_opcode, ifs.out_fmt, ifs.out_rd, ifs.out_rs1,
            ifs.out_rs2, ifs.out_f3, ifs.out_f7, ifs.out_imm, ifs.out_rd_we,
            ifs.out_rs1_en, ifs.out_rs2_en, ifs.out_illegal};
  endfunction

  function automatic logic [166:0] dut64_pack();
    return {if64.out_pc, if64.out_opcode, if64.out_fmt, if64.out_rd, if64.out_rs1,
            if64.out_rs2, if64.out_f3, if64.out_f7, if64.out_imm, if64.out_rd_we,
            if64.out_rs1_en, if64.out_rs2_en, if64.out_illegal};
  endfunction

  task automatic offer(exp_t e);
    cur      = e;
    cur.pc   = pc_ctr;
    pc_ctr   = pc_ctr + 64'd4;
    in_instr = cur.instr;
    in_pc    = cur.pc;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // One clock: check in_ready, advance the model, then check the output entry.
  task automatic tick();
    logic exp_rdy;
    logic acc;
    exp_t e;
    #1;
    exp_rdy = (!mvld || out_ready) && !flush;
    n_run++;
    if ({if32.in_ready, if64.in_ready, ifs.in_ready} !== {3{exp_rdy}}) begin
      n_fail++;
      $display("FAIL in_ready: got %b want %b", {if32.in_ready, if64.in_ready, ifs.in_ready},
               {3{exp_rdy}});
    end
    acc = in_valid && exp_rdy;
    @(posedge clk);
    if (flush) begin
      sb.delete();
      mvld = 1'b0;
    end else if (acc) begin
      if (mvld) void'(sb.pop_front());
      sb.push_back(cur);
      mvld = 1'b1;
      if (cur.ill32 && cnt32_m != 65535) cnt32_m++;
      if (cur.ill64 && cnt64_m != 65535) cnt64_m++;
      if (cur.ill32 && cnts_m != 3) cnts_m++;
    end else if (mvld && out_ready) begin
      void'(sb.pop_front());
      mvld = 1'b0;
    end
    #1;
    n_run++;
    if ({if32.out_valid, if64.out_valid, ifs.out_valid} !== {3{mvld}}) begin
      n_fail++;
      $display("FAIL out_valid: got %b want %b", {if32.out_valid, if64.out_valid, ifs.out_valid},
               {3{mvld}});
    end
    if (mvld) begin
      e = sb[0];
      n_run++;
      if (dut32_pack() !== pack32(e)) begin
        n_fail++;
        $display("FAIL entry32 %h: got %h want %h", e.instr, dut32_pack(), pack32(e));
      end
      n_run++;
      if (dut64_pack() !== pack64(e)) begin
        n_fail++;
        $display("FAIL entry64 %h: got %h want %h", e.instr, dut64_pack(), pack64(e));
      end
      n_run++;
      if (dutsat_pack() !== pack32(e)) begin
        n_fail++;
        $display("FAIL entry_sat %h: got %h want %h", e.instr, dutsat_pack(), pack32(e));
      end
    end
    n_run++;
    if ({cnt32, cnt64, cnts} !== {16'(cnt32_m), 16'(cnt64_m), 2'(cnts_m)}) begin
      n_fail++;
      $display("FAIL illegal_cnt: got %h/%h/%h want %0d/%0d/%0d", cnt32, cnt64, cnts,
               cnt32_m, cnt64_m, cnts_m);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
    sb.delete(); mvld = 1'b0; cnt32_m = 0; cnt64_m = 0; cnts_m = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if ({if32.out_valid, if64.out_valid, ifs.out_valid, cnt32, cnt64, cnts} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b%b%b cnt %h/%h/%h want all 0", if32.out_valid,
               if64.out_valid, ifs.out_valid, cnt32, cnt64, cnts);
    end
    n_run++;
    if (dut32_pack() !== 103'd0 || dut64_pack() !== 167'd0) begin
      n_fail++;
      $display("FAIL reset_fields: got %h / %h want 0", dut32_pack(), dut64_pack());
    end
    n_run++;
    if (if32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", if32.in_ready);
    end
  endtask

  task automatic test_decode();
    exp_t v[$];
    v.push_back(mk(32'hFFF00093, FMT_I, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 0));
    v.push_back(mk(32'hFE000EE3, FMT_B, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 1, 0, 0));
    v.push_back(mk(32'h00208033, FMT_R, 64'h0, 0, 1, 1, 0, 0));
    v.push_back(mk(32'hFE20AC23, FMT_S, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1, 1, 0, 0));
    v.push_back(mk(32'h008000EF, FMT_J, 64'h8, 1, 0, 0, 0, 0));
    v.push_back(mk(32'h00000073, FMT_I, 64'h0, 0, 0, 0, 0, 0));
    v.push_back(mk(32'h00100073, FMT_I, 64'h1, 0, 0, 0, 0, 0));
    v.push_back(mk(32'h0FF0000F, FMT_I, 64'hFF, 0, 0, 0, 0, 0));
    v.push_back(mk(32'h123452B7, FMT_U, 64'h0000_0000_1234_5000, 1, 0, 0, 0, 0));
    v.push_back(mk(32'h800002B7, FMT_U, 64'hFFFF_FFFF_8000_0000, 1, 0, 0, 0, 0));
    v.push_back(mk(32'h0000B083, FMT_I, 64'h0, 1, 1, 0, 1, 0));
    v.push_back(mk(32'h02009093, FMT_I, 64'h20, 1, 1, 0, 1, 0));
    v.push_back(mk(32'h4200D093, FMT_I, 64'h420, 1, 1, 0, 1, 0));
    out_ready = 1'b1;
    foreach (v[i]) begin
      offer(v[i]);
      tick();
    end
    idle();
    tick();
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    offer(mk(32'h40001033, FMT_NONE, 64'h0, 0, 0, 0, 1, 1)); tick();
    offer(mk(32'h00000000, FMT_NONE, 64'h0, 0, 0, 0, 1, 1)); tick();
    offer(mk(32'h00001073, FMT_NONE, 64'h0, 0, 0, 0, 1, 1)); tick();
    idle(); tick();
    n_run++;
    if (cnt32 !== 16'd3 || cnt64 !== 16'd3 || cnts !== 2'd3) begin
      n_fail++;
      $display("FAIL illegal_three: got %0d/%0d/%0d want 3/3/3", cnt32, cnt64, cnts);
    end
    offer(mk(32'h00000000, FMT_NONE, 64'h0, 0, 0, 0, 1, 1)); tick();
    idle(); tick();
    n_run++;
    if (cnts !== 2'd3 || cnt32 !== 16'd4) begin
      n_fail++;
      $display("FAIL illegal_saturate: got sat %0d wide %0d want 3 and 4", cnts, cnt32);
    end
  endtask

  task automatic test_backpressure();
    exp_t a;
    exp_t b;
    do_reset();
    out_ready = 1'b1;
    offer(mk(32'hFFF00093, FMT_I, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 0));
    a = cur;
    tick();
    out_ready = 1'b0;
    offer(mk(32'hFE000EE3, FMT_B, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 1, 0, 0));
    b = cur;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_run++;
      if (dut32_pack() !== pack32(a) || if32.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d: got %h rdy %b want %h rdy 0", k, dut32_pack(),
                 if32.in_ready, pack32(a));
      end
    end
    out_ready = 1'b1;
    tick();
    n_run++;
    if (dut64_pack() !== pack64(b)) begin
      n_fail++;
      $display("FAIL release: got %h want %h", dut64_pack(), pack64(b));
    end
    idle();
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    offer(mk(32'h00208033, FMT_R, 64'h0, 0, 1, 1, 0, 0));
    tick();
    offer(mk(32'h00000000, FMT_NONE, 64'h0, 0, 0, 0, 1, 1));
    flush = 1'b1;
    tick();
    n_run++;
    if (if32.out_valid !== 1'b0 || cnt32 !== 16'd0 || cnts !== 2'd0) begin
      n_fail++;
      $display("FAIL flush: got vld %b cnt %0d/%0d want vld 0 cnt 0/0", if32.out_valid,
               cnt32, cnts);
    end
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    offer(mk(32'h00000000, FMT_NONE, 64'h0, 0, 0, 0, 1, 1));
    tick();
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({if32.out_valid, if64.out_valid, ifs.out_valid} !== 3'b000 || cnt32 !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: got vld %b%b%b cnt %0d want 000 cnt 0", if32.out_valid,
               if64.out_valid, ifs.out_valid, cnt32);
    end
    sb.delete(); mvld = 1'b0; cnt32_m = 0; cnt64_m = 0; cnts_m = 0;
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_run = 0; n_fail = 0; mvld = 1'b0;
    cnt32_m = 0; cnt64_m = 0; cnts_m = 0;
    pc_ctr = 64'hFFFF_FFF0_8000_0000;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    test_reset();
    test_decode();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
